// File: rtl/csi_raw_unpacker.sv
// CSI-2 RAW8/RAW10/RAW12 byte-stream unpacker: buffers lane bytes and emits
// groups of four MSB-aligned pixels through a valid/ready handshake.
module csi_raw_unpacker #(
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned PIXEL_WIDTH = 12,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [8*NUM_LANES-1:0]     image_data,
    input  logic                       image_data_enable,
    input  logic [5:0]                 image_data_type,
    input  logic                       frame_start,
    output logic [4*PIXEL_WIDTH-1:0]   pixels,
    output logic                       pixels_valid,
    input  logic                       pixels_ready,
    output logic                       frame_start_out,
    output logic                       overflow,
    output logic                       unsupported
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = 4 * PIXEL_WIDTH;

    if (DEPTH < NUM_LANES + 6) begin : g_depth_chk
        $error("csi_raw_unpacker: DEPTH must be >= NUM_LANES+6");
    end
    if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_lane_chk
        $error("csi_raw_unpacker: NUM_LANES must be 1, 2 or 4");
    end

    typedef enum logic [2:0] {M_NONE, M_RAW8, M_RAW10, M_RAW12, M_BAD} mode_e;

    function automatic mode_e decode(input logic [5:0] dt);
        case (dt)
            6'h2A:   return M_RAW8;
            6'h2B:   return M_RAW10;
            6'h2C:   return M_RAW12;
            default: return M_BAD;
        endcase
    endfunction

    function automatic int grp_bytes(input mode_e m);
        case (m)
            M_RAW8:  return 4;
            M_RAW10: return 5;
            M_RAW12: return 6;
            default: return 0;
        endcase
    endfunction

    logic [7:0]    buf_q [DEPTH];
    logic [7:0]    buf_d [DEPTH];
    logic [7:0]    shifted [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    mode_e         mode_q, mode_d, mode_eff;
    logic [OW-1:0] pixels_q, pixels_d;
    logic          valid_q, valid_d;
    logic          fso_q, ovf_q, ovf_d, unsup_q, unsup_d;
    logic          pop, push;
    int            g_pop, cnt_pop;
    logic [15:0]   src [4];

    // Buffer update, mode latch and next output group from post-update state
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        unsup_d  = unsup_q;
        pixels_d = pixels_q;
        valid_d  = 1'b0;
        for (int k = 0; k < 4; k++) src[k] = '0;

        mode_eff = mode_q;
        if (mode_q == M_NONE && image_data_enable) mode_eff = decode(image_data_type);
        pop     = valid_q && pixels_ready;
        g_pop   = pop ? grp_bytes(mode_q) : 0;
        cnt_pop = int'(cnt_q) - g_pop;
        push    = image_data_enable && (mode_eff != M_BAD);

        for (int j = 0; j < int'(DEPTH); j++) begin
            shifted[j] = (g_pop == 0) ? buf_q[j] : 8'h00;
            for (int g = 4; g <= 6; g++) begin
                if (g_pop == g && j + g < int'(DEPTH)) shifted[j] = buf_q[(j + g) % int'(DEPTH)];
            end
        end

        if (frame_start) begin
            mode_d  = M_NONE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            unsup_d = 1'b0;
        end else begin
            mode_d  = mode_eff;
            unsup_d = unsup_q | (mode_eff == M_BAD);
            buf_d   = shifted;
            cnt_d   = CW'(cnt_pop);
            if (push) begin
                if (cnt_pop + int'(NUM_LANES) <= int'(DEPTH)) begin
                    // Whole beat lands after the surviving bytes
                    for (int j = 0; j < int'(DEPTH); j++) begin
                        for (int i = 0; i < int'(NUM_LANES); i++) begin
                            if (j == cnt_pop + i) buf_d[j] = image_data[i*8 +: 8];
                        end
                    end
                    cnt_d = CW'(cnt_pop + int'(NUM_LANES));
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        // Each source pixel left-aligned in 16 bits, then top PIXEL_WIDTH bits taken
        for (int k = 0; k < 4; k++) begin
            case (mode_d)
                M_RAW8:  src[k] = {buf_d[k], 8'h00};
                M_RAW10: src[k] = {buf_d[k], buf_d[4][2*k +: 2], 6'h00};
                default: src[k] = 16'h0000;
            endcase
        end
        if (mode_d == M_RAW12) begin
            src[0] = {buf_d[0], buf_d[2][3:0], 4'h0};
            src[1] = {buf_d[1], buf_d[2][7:4], 4'h0};
            src[2] = {buf_d[3], buf_d[5][3:0], 4'h0};
            src[3] = {buf_d[4], buf_d[5][7:4], 4'h0};
        end

        valid_d = (mode_d == M_RAW8 || mode_d == M_RAW10 || mode_d == M_RAW12)
                  && (int'(cnt_d) >= grp_bytes(mode_d));
        if (valid_d) begin
            for (int k = 0; k < 4; k++) pixels_d[k*PIXEL_WIDTH +: PIXEL_WIDTH] = src[k][15 -: PIXEL_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < int'(DEPTH); j++) buf_q[j] <= 8'h00;
            cnt_q    <= '0;
            mode_q   <= M_NONE;
            pixels_q <= '0;
            valid_q  <= 1'b0;
            fso_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unsup_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            pixels_q <= pixels_d;
            valid_q  <= valid_d;
            fso_q    <= frame_start;
            ovf_q    <= ovf_d;
            unsup_q  <= unsup_d;
        end
    end

    assign pixels          = pixels_q;
    assign pixels_valid    = valid_q;
    assign frame_start_out = fso_q;
    assign overflow        = ovf_q;
    assign unsupported     = unsup_q;
endmodule

// File: tb/tb_csi_raw_unpacker.sv
// Directed bench for csi_raw_unpacker (2 lanes, 12-bit pixels, 16-byte buffer)
// with a queue-based scoreboard checking every accepted pixel group.
module tb_csi_raw_unpacker;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] image_data;
    logic        image_data_enable;
    logic [5:0]  image_data_type;
    logic        frame_start;
    logic [47:0] pixels;
    logic        pixels_valid;
    logic        pixels_ready;
    logic        frame_start_out;
    logic        overflow;
    logic        unsupported;

    int errors = 0;
    int checks = 0;
    logic [47:0] exp_q [$];

    csi_raw_unpacker #(.NUM_LANES(2), .PIXEL_WIDTH(12), .DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .image_data(image_data),
        .image_data_enable(image_data_enable), .image_data_type(image_data_type),
        .frame_start(frame_start), .pixels(pixels), .pixels_valid(pixels_valid),
        .pixels_ready(pixels_ready), .frame_start_out(frame_start_out),
        .overflow(overflow), .unsupported(unsupported)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, expv);
        end
    endtask

    // Monitor: every accepted group must match the oldest expected one
    always @(negedge clk) begin
        if (reset_n && pixels_valid && pixels_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_group: got=%h expected=none", pixels);
            end else begin
                chk("group", pixels, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic [5:0] t);
        image_data = d;
        image_data_type = t;
        image_data_enable = 1'b1;
        cyc();
        image_data_enable = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("fso_pulse", 48'(frame_start_out), 48'd1);
        cyc();
        chk("fso_clear", 48'(frame_start_out), 48'd0);
    endtask

    function automatic logic [47:0] raw8_grp(input logic [7:0] b0, b1, b2, b3);
        return {b3, 4'h0, b2, 4'h0, b1, 4'h0, b0, 4'h0};
    endfunction

    initial begin
        reset_n = 1'b0;
        image_data = '0;
        image_data_enable = 1'b0;
        image_data_type = '0;
        frame_start = 1'b0;
        pixels_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_pixels", pixels, 48'd0);
        chk("rst_valid", 48'(pixels_valid), 48'd0);
        chk("rst_fso", 48'(frame_start_out), 48'd0);
        chk("rst_ovf", 48'(overflow), 48'd0);
        chk("rst_unsup", 48'(unsupported), 48'd0);
        reset_n = 1'b1;
        cyc();

        // RAW8 single group, valid for exactly one cycle
        fs();
        exp_q.push_back({12'h040, 12'h030, 12'h020, 12'h010});
        beat(16'h0201, 6'h2A);
        chk("raw8_valid_early", 48'(pixels_valid), 48'd0);
        beat(16'h0403, 6'h2A);
        chk("raw8_valid", 48'(pixels_valid), 48'd1);
        cyc();
        chk("raw8_valid_1cyc", 48'(pixels_valid), 48'd0);

        // RAW10
        fs();
        exp_q.push_back({12'hD0C, 12'hC08, 12'hB04, 12'hA00});
        beat(16'hB0A0, 6'h2B);
        beat(16'hD0C0, 6'h2B);
        beat(16'h00E4, 6'h2B);
        repeat (3) cyc();

        // RAW12
        fs();
        exp_q.push_back({12'h9AB, 12'h78C, 12'h345, 12'h126});
        beat(16'h3412, 6'h2C);
        beat(16'h7856, 6'h2C);
        beat(16'hBC9A, 6'h2C);
        repeat (3) cyc();

        // Overflow: 8 beats fill 16 bytes, ninth beat dropped whole
        fs();
        pixels_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            beat({8'(2*i+1), 8'(2*i)}, 6'h2A);
            if (i == 7) chk("ovf_full_no_flag", 48'(overflow), 48'd0);
        end
        chk("ovf_set", 48'(overflow), 48'd1);
        chk("ovf_valid_held", 48'(pixels_valid), 48'd1);
        for (int g = 0; g < 4; g++)
            exp_q.push_back(raw8_grp(8'(4*g), 8'(4*g+1), 8'(4*g+2), 8'(4*g+3)));
        pixels_ready = 1'b1;
        repeat (8) cyc();
        chk("ovf_sticky", 48'(overflow), 48'd1);
        fs();
        chk("ovf_cleared", 48'(overflow), 48'd0);

        // Unsupported type, then recovery
        beat(16'h1234, 6'h1E);
        chk("unsup_set", 48'(unsupported), 48'd1);
        beat(16'h5678, 6'h2A);
        beat(16'h9ABC, 6'h2A);
        cyc();
        chk("unsup_no_valid", 48'(pixels_valid), 48'd0);
        chk("unsup_sticky", 48'(unsupported), 48'd1);
        fs();
        chk("unsup_cleared", 48'(unsupported), 48'd0);
        exp_q.push_back(raw8_grp(8'hAA, 8'hBB, 8'hCC, 8'hDD));
        beat(16'hBBAA, 6'h2A);
        beat(16'hDDCC, 6'h2A);
        repeat (3) cyc();

        // Async reset mid-frame drops outputs immediately, nothing stale after
        fs();
        pixels_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(16'hF0F1, 6'h2A);
        chk("pre_rst_valid", 48'(pixels_valid), 48'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 48'(pixels_valid), 48'd0);
        chk("async_rst_pixels", pixels, 48'd0);
        cyc();
        reset_n = 1'b1;
        pixels_ready = 1'b1;
        exp_q.push_back(raw8_grp(8'h11, 8'h22, 8'h33, 8'h44));
        beat(16'h2211, 6'h2A);
        beat(16'h4433, 6'h2A);
        repeat (3) cyc();

        // Residual bytes and a colliding beat are flushed by frame_start
        beat(16'hEEFF, 6'h2A);
        cyc();
        chk("partial_held", 48'(pixels_valid), 48'd0);
        image_data = 16'h9999;
        image_data_type = 6'h2A;
        image_data_enable = 1'b1;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        image_data_enable = 1'b0;
        chk("fso_flush_pulse", 48'(frame_start_out), 48'd1);
        chk("flush_no_valid", 48'(pixels_valid), 48'd0);
        cyc();
        chk("fso_flush_clear", 48'(frame_start_out), 48'd0);
        exp_q.push_back(raw8_grp(8'h55, 8'h66, 8'h77, 8'h88));
        beat(16'h6655, 6'h2A);
        beat(16'h8877, 6'h2A);
        repeat (4) cyc();

        chk("scoreboard_drained", 48'(exp_q.size()), 48'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
